// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the modular-ADC command scheduler.
package adc_sched_pkg;

    localparam int unsigned ADC_CH_W = 5;
    localparam int unsigned ADC_DW   = 12;

    localparam logic [ADC_CH_W-1:0] ADC_CH_TEMP = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/adc_scheduler_rr_arbiter.sv
// Round-robin pick: first set pending bit at or after rr_ptr, wrapping to 0.
module rr_arbiter
    import adc_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         pending,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic                    any,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] cand;

    // Scan from the farthest candidate back to rr_ptr so the nearest set bit wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            cand = IW'((32'(rr_ptr) + 32'(k)) % NREQ);
            if (pending[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/adc_scheduler.sv
// Shares the modular-ADC command/response channel among NREQ requesters.
module adc_scheduler
    import adc_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned DW      = ADC_DW
) (
    input  logic                      clock_in,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_pulse,
    input  logic [ADC_CH_W*NREQ-1:0]  req_channel,
    output logic                      cmd_valid,
    output logic [ADC_CH_W-1:0]       cmd_channel,
    output logic                      cmd_sop,
    output logic                      cmd_eop,
    input  logic                      cmd_ready,
    input  logic                      rsp_valid,
    input  logic [ADC_CH_W-1:0]       rsp_channel,
    input  logic [DW-1:0]             rsp_data,
    output logic [NREQ-1:0]           done,
    output logic [DW-1:0]             data_out,
    output logic                      error,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    sched_state_t state_q, state_d;

    logic [NREQ-1:0]     pending_q;
    logic [ADC_CH_W-1:0] ch_q [NREQ];
    logic [NREQ-1:0]     grant_clr;

    logic [IW-1:0]       rr_q, rr_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [IW-1:0]       grant_d;
    logic [ADC_CH_W-1:0] chan_d;
    logic [DW-1:0]       data_d;
    logic                error_d;
    logic [NREQ-1:0]     done_d;

    logic                arb_any;
    logic [IW-1:0]       arb_idx;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .pending (pending_q),
        .rr_ptr  (rr_q),
        .any     (arb_any),
        .idx     (arb_idx)
    );

    // Pending bank: a new pulse beats a same-cycle grant clear so the request stays queued.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            for (int i = 0; i < int'(NREQ); i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            pending_q <= (pending_q & ~grant_clr) | req_pulse;
            for (int i = 0; i < int'(NREQ); i++) begin
                if (req_pulse[i]) begin
                    ch_q[i] <= req_channel[ADC_CH_W*i +: ADC_CH_W];
                end
            end
        end
    end

    // Next-state and next-output logic; grant_id/cmd_channel double as the transaction latch.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_id;
        chan_d    = cmd_channel;
        rr_d      = rr_q;
        timer_d   = timer_q;
        data_d    = data_out;
        error_d   = error;
        grant_clr = '0;
        done_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d            = arb_idx;
                    chan_d             = ch_q[arb_idx];
                    grant_clr[arb_idx] = 1'b1;
                    rr_d               = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
                    state_d            = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cmd_valid && cmd_ready) begin
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    data_d  = rsp_data;
                    error_d = (rsp_channel != cmd_channel);
                    state_d = ST_DONE;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    data_d  = '0;
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_DONE) begin
            done_d[grant_d] = 1'b1;
        end
    end

    // State register plus registered outputs derived from the next state.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            timer_q     <= '0;
            grant_id    <= '0;
            cmd_channel <= '0;
            cmd_valid   <= 1'b0;
            cmd_sop     <= 1'b0;
            cmd_eop     <= 1'b0;
            data_out    <= '0;
            error       <= 1'b0;
            done        <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            timer_q     <= timer_d;
            grant_id    <= grant_d;
            cmd_channel <= chan_d;
            cmd_valid   <= (state_d == ST_CMD);
            cmd_sop     <= (state_d == ST_CMD);
            cmd_eop     <= (state_d == ST_CMD);
            data_out    <= data_d;
            error       <= error_d;
            done        <= done_d;
            busy        <= (state_d != ST_IDLE);
        end
    end

endmodule
